// File: rtl/clmul_pkg.sv
// Package for the shared carry-less multiplier scheduler.
// Holds the default reduction polynomial, the raw product width, the
// operand payload carried through the operand stage, and the GF(2^8)
// reduction helper used between the operand and result stages.
package clmul_pkg;

  // Low byte of x^8 + x^4 + x^3 + x + 1 (AES field polynomial).
  localparam logic [7:0] GF8_POLY_AES = 8'h1B;

  // Meaningful width of an 8x8 carry-less product (degree <= 14).
  localparam int PROD_W = 15;

  // Operand payload latched by the operand stage.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       red;
  } op_t;

  // Reduce a raw 15-bit carry-less product modulo x^8 + poly.
  // High bits are folded from the top down so that each fold can only
  // disturb bits strictly below the one being cleared.
  function automatic logic [7:0] gf8_reduce(input logic [PROD_W-1:0] p,
                                            input logic [7:0]        poly);
    logic [PROD_W-1:0] t;
    t = p;
    for (int k = PROD_W - 1; k >= 8; k--) begin
      if (t[k]) begin
        t = t ^ ({7'd0, poly} << (k - 8));
      end else begin
        t = t;
      end
      t[k] = 1'b0;
    end
    return t[7:0];
  endfunction

endpackage

// File: rtl/clmul_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter with internal priority pointer.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   req      : per-requester request lines
//   en       : grant enable (downstream has room)
//   adv      : a grant was accepted this cycle; move the pointer to it
//   gnt      : one-hot grant, zero when disabled or nothing requested
//   gnt_idx  : binary index of the winning requester
// After reset the pointer sits at N-1 so requester 0 is searched first.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             adv,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             hi_found_s;
  logic             lo_found_s;
  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;

  // Two-pass search: first requester above the pointer wins, else the
  // lowest requester at or below it (this wraps the search order).
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (IDX_W'(i) > ptr_q) && !hi_found_s) begin
        hi_found_s = 1'b1;
        hi_idx_s   = IDX_W'(i);
      end else if (req[i] && (IDX_W'(i) <= ptr_q) && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_idx_s   = IDX_W'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    any_s = hi_found_s | lo_found_s;
  end

  assign gnt     = (en && any_s) ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : '0;
  assign gnt_idx = idx_s;

  // Pointer follows the winner only when its handshake completes.
  always_comb begin
    if (adv) begin
      ptr_d = idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_free_8bit.sv
// Combinational 8x8 carry-less (GF(2) polynomial) multiplier.
// Ports:
//   a, b   : 8-bit operands
//   mul_8  : 17-bit product bus; only [14:0] carries product bits, the
//            upper two bits are always zero.
module mul_free_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [16:0] mul_8
);

  logic [16:0] acc_s;

  // XOR-accumulate shifted copies of b for every set bit of a.
  always_comb begin
    acc_s = 17'd0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) begin
        acc_s = acc_s ^ ({9'd0, b} << i);
      end else begin
        acc_s = acc_s;
      end
    end
  end

  assign mul_8 = acc_s;

endmodule

// File: rtl/clmul_rr_scheduler.sv
// Shares one carry-less multiplier among N_REQ requesters.
// Round-robin arbitration feeds a two-stage pipeline (operand register,
// then result register); products are optionally reduced mod x^8+POLY.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot)
//   req_a, req_b         : packed operands, requester i at [8i+7:8i]
//   req_red              : per-requester reduce-mod-poly select
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id               : index of the requester served
//   rsp_data             : raw {1'b0,clmul[14:0]} or reduced {8'h00,r}
//   ops_cnt              : completed responses, wrapping
module clmul_rr_scheduler
  import clmul_pkg::*;
#(
  parameter int         N_REQ = 4,
  parameter int         ID_W  = 2,
  parameter logic [7:0] POLY  = GF8_POLY_AES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]   req_red,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_data,
  output logic [31:0]        ops_cnt
);

  logic              s2_free_s;
  logic              s1_free_s;
  logic              arb_en_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic              any_gnt_s;
  op_t               sel_op_s;

  logic              s1_v_q,   s1_v_d;
  op_t               s1_op_q,  s1_op_d;
  logic [ID_W-1:0]   s1_id_q,  s1_id_d;

  logic              s2_v_q,    s2_v_d;
  logic [ID_W-1:0]   s2_id_q,   s2_id_d;
  logic [15:0]       s2_data_q, s2_data_d;
  logic [31:0]       cnt_q,     cnt_d;

  logic [16:0]       mul_8_s;
  logic [PROD_W-1:0] prod_s;
  logic [15:0]       res_s;
  logic              unused_mul_hi_s;

  // A stage can take new data if it is empty or its content moves on.
  assign s2_free_s = !s2_v_q || rsp_ready;
  assign s1_free_s = !s1_v_q || s2_free_s;
  // No grants while reset is asserted, so nothing is accepted then.
  assign arb_en_s  = s1_free_s && !rst;
  assign any_gnt_s = |gnt_s;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en_s),
    .adv     (any_gnt_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign req_ready = gnt_s;

  // One-hot AND-OR mux of the granted requester's operands.
  always_comb begin
    sel_op_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_op_s.a   = sel_op_s.a   | (req_a[8*i +: 8] & {8{gnt_s[i]}});
      sel_op_s.b   = sel_op_s.b   | (req_b[8*i +: 8] & {8{gnt_s[i]}});
      sel_op_s.red = sel_op_s.red | (req_red[i] & gnt_s[i]);
    end
  end

  // Operand stage next state: load on grant, empty if free and idle.
  always_comb begin
    s1_v_d  = s1_v_q;
    s1_op_d = s1_op_q;
    s1_id_d = s1_id_q;
    if (s1_free_s) begin
      s1_v_d = any_gnt_s;
      if (any_gnt_s) begin
        s1_op_d = sel_op_s;
        s1_id_d = gnt_idx_s;
      end else begin
        s1_op_d = s1_op_q;
        s1_id_d = s1_id_q;
      end
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  mul_free_8bit u_mul (
    .a     (s1_op_q.a),
    .b     (s1_op_q.b),
    .mul_8 (mul_8_s)
  );

  // Only [14:0] is a product; the top bits are deliberately dropped.
  assign prod_s          = mul_8_s[PROD_W-1:0];
  assign unused_mul_hi_s = ^mul_8_s[16:15];
  assign res_s = s1_op_q.red ? {8'h00, gf8_reduce(prod_s, POLY)}
                             : {1'b0, prod_s};

  // Result stage next state and response counter.
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_id_d   = s2_id_q;
    s2_data_d = s2_data_q;
    cnt_d     = cnt_q;
    if (s2_free_s) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_id_d   = s1_id_q;
        s2_data_d = res_s;
      end else begin
        s2_id_d   = s2_id_q;
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_v_d = s2_v_q;
    end
    if (s2_v_q && rsp_ready) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_op_q   <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_id_q   <= '0;
      s2_data_q <= 16'h0000;
      cnt_q     <= 32'd0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_op_q   <= s1_op_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_id_q   <= s2_id_d;
      s2_data_q <= s2_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_data  = s2_data_q;
  assign ops_cnt   = cnt_q;

endmodule

// File: tb/tb_clmul_rr_scheduler.sv
// Bench for clmul_rr_scheduler: directed tests plus a random mix, checked
// every cycle against a transaction-level model (in-flight queue, RR
// pointer, arithmetic reference for clmul and GF(2^8) multiplication).
module tb_clmul_rr_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]   req_red;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [15:0]    rsp_data;
  logic [31:0]    ops_cnt;

  clmul_rr_scheduler #(.N_REQ(N), .ID_W(2), .POLY(8'h1B)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_red   (req_red),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .ops_cnt   (ops_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: raw product as a sum over bit pairs a[i]*b[j] -> x^(i+j).
  function automatic logic [15:0] ref_raw(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j]) r = r ^ (16'h0001 << (i + j));
    return r;
  endfunction

  // Reference: field product via shift-and-add with xtime.
  function automatic logic [15:0] ref_gf(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1B;
      bb = bb >> 1;
    end
    return {8'h00, p};
  endfunction

  function automatic logic [15:0] ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic red);
    return red ? ref_gf(a, b) : ref_raw(a, b);
  endfunction

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       red;
  } op_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    int          t;
  } exp_t;

  // Model state.
  exp_t        q[$];
  int          ptr_m = N - 1;
  logic [31:0] cnt_m = 32'd0;
  int          t_cyc = 0;
  logic [N-1:0] exp_gnt;
  logic        exp_valid;
  int          g_idx;

  // Driver state.
  op_t         pend[N][$];
  int          gap[N];
  logic [N-1:0] acc_mask = '0;
  int          rdy_mode = 0;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
      q.delete();
      ptr_m    = N - 1;
      cnt_m    = 32'd0;
      acc_mask = '0;
    end else begin
      exp_valid = (q.size() > 0) && (t_cyc - q[0].t >= 2);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, q[0].id});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, q[0].data});
      end
      chk("ops_cnt", ops_cnt, cnt_m);
      exp_gnt = '0;
      if (q.size() < 2 || rsp_ready) begin
        for (int off = 1; off <= N; off++) begin
          g_idx = (ptr_m + off) % N;
          if (exp_gnt == '0 && req_valid[g_idx]) exp_gnt = 4'b0001 << g_idx;
        end
      end
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_gnt});
      acc_mask = req_valid & req_ready;
      if (exp_valid && rsp_ready) begin
        void'(q.pop_front());
        cnt_m = cnt_m + 32'd1;
      end
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) begin
          q.push_back('{id: 2'(i), data: ref_rsp(req_a[8*i +: 8], req_b[8*i +: 8], req_red[i]), t: t_cyc});
          ptr_m = i;
        end
      end
    end
    t_cyc++;
  end

  // Update requester lines from the pending lists after a clock edge.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        void'(pend[i].pop_front());
        req_valid[i] = 1'b0;
        gap[i] = (rdy_mode == 1) ? int'($urandom_range(0, 2)) : 0;
      end
      if (req_valid[i]) begin
        // held until accepted
      end else if (gap[i] > 0) begin
        gap[i]--;
      end else if (pend[i].size() > 0) begin
        req_valid[i]     = 1'b1;
        req_a[8*i +: 8]  = pend[i][0].a;
        req_b[8*i +: 8]  = pend[i][0].b;
        req_red[i]       = pend[i][0].red;
      end
    end
    if (rdy_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit idle();
    bit r;
    r = (q.size() == 0) && (req_valid == '0);
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic run_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      step();
      if (idle()) return;
    end
    checks++;
    errors++;
    $display("FAIL run_idle: timeout after %0d cycles, got busy expected idle", bound);
  endtask

  task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic red, input logic [15:0] exp);
    pend[id].push_back('{a: a, b: b, red: red});
    step();
    @(negedge clk);
    chk("single_gnt", {28'd0, req_ready}, 32'd1 << id);
    step();
    @(negedge clk);
    chk("single_early", {31'd0, rsp_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_id", {30'd0, rsp_id}, id);
    chk("single_data", {16'd0, rsp_data}, {16'd0, exp});
    step();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t o;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_red = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) gap[i] = 0;

    // Pin the reference model with hand-computed products.
    chk("model_raw_57_83", {16'd0, ref_raw(8'h57, 8'h83)}, 32'h0000_2B79);
    chk("model_gf_57_83",  {16'd0, ref_gf(8'h57, 8'h83)},  32'h0000_00C1);
    chk("model_raw_ff_ff", {16'd0, ref_raw(8'hFF, 8'hFF)}, 32'h0000_5555);

    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_id",    {30'd0, rsp_id},    32'd0);
    chk("reset_data",  {16'd0, rsp_data},  32'd0);
    chk("reset_cnt",   ops_cnt,            32'd0);

    // Single ops, raw and reduced.
    single_op(0, 8'h57, 8'h83, 1'b0, 16'h2B79);
    single_op(1, 8'h57, 8'h83, 1'b1, 16'h00C1);
    single_op(3, 8'hFF, 8'hFF, 1'b0, 16'h5555);
    run_idle(20);

    // Fairness: all four continuously valid, pointer currently at 3.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) pend[i].push_back('{a: 8'(i + 1), b: 8'(r + 5), red: r[0]});
    for (int k = 0; k < 12; k++) begin
      step();
      @(negedge clk);
      chk("fair_gnt", {28'd0, req_ready}, 32'd1 << (k % 4));
    end
    run_idle(50);

    // Backpressure with four ops queued, after a fresh reset.
    step(); rst = 1'b1;
    step(); rst = 1'b0; rsp_ready = 1'b0;
    pend[0].push_back('{a: 8'h57, b: 8'h83, red: 1'b0});
    pend[1].push_back('{a: 8'h57, b: 8'h83, red: 1'b1});
    pend[2].push_back('{a: 8'hFF, b: 8'hFF, red: 1'b0});
    pend[3].push_back('{a: 8'h02, b: 8'h03, red: 1'b0});
    step(); step();
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("bp_ready",    {28'd0, req_ready}, 32'd0);
      chk("bp_valid",    {31'd0, rsp_valid}, 32'd1);
      chk("bp_id",       {30'd0, rsp_id},    32'd0);
      chk("bp_data",     {16'd0, rsp_data},  32'h0000_2B79);
    end
    step(); rsp_ready = 1'b1;
    run_idle(50);
    @(negedge clk);
    chk("bp_ops_cnt", ops_cnt, 32'd4);

    // Reset with both stages full.
    step(); rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) pend[i].push_back('{a: 8'(8'h10 + i), b: 8'h0F, red: 1'b1});
    step(); step(); step(); step();
    rst = 1'b1;
    pend[0].push_back('{a: 8'h10, b: 8'h0F, red: 1'b1});
    pend[1].push_back('{a: 8'h11, b: 8'h0F, red: 1'b1});
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_cnt",   ops_cnt,            32'd0);
    chk("rst_mid_gnt",   {28'd0, req_ready}, 32'd1);
    step(); rsp_ready = 1'b1;
    run_idle(50);

    // Random mix with random backpressure and requester gaps.
    step(); rdy_mode = 1;
    for (int n = 0; n < 10000; n++) begin
      o.a   = 8'($urandom);
      o.b   = 8'($urandom);
      o.red = 1'($urandom);
      pend[$urandom_range(0, N - 1)].push_back(o);
    end
    run_idle(60000);
    rdy_mode = 0; rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
